// File: rtl/frame_seq_ctrl_pkg.sv
// Shared types and defaults for the frame sequencer slice.
package img_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;

  // Sequencer FSM encoding; also shown on the LEDs.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } seq_state_e;

  // Filter kernels understood by the filter core.
  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_BLUR    = 2'd1,
    MODE_SHARPEN = 2'd2,
    MODE_EDGE    = 2'd3
  } filt_mode_e;

endpackage

// File: rtl/frame_seq_ctrl_if.sv
// Byte/pixel stream bundle between UART RX, filter core and UART TX.
// Every stream uses valid/ready: a beat moves in a cycle where both are
// high; a source never waits for ready before raising valid, and holds
// data stable while valid is high and ready is low.
interface frame_seq_ctrl_if
  import img_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);
  logic [PIX_W-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [PIX_W-1:0] f_in_data;
  logic             f_in_valid;
  logic             f_in_sof;
  logic             f_in_eol;
  logic             f_in_ready;
  logic [1:0]       f_mode;
  logic [PIX_W-1:0] f_out_data;
  logic             f_out_valid;
  logic             f_out_ready;
  logic [PIX_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  // Sequencer side.
  modport master (
    input  rx_data, rx_valid, f_in_ready, f_out_data, f_out_valid, tx_ready,
    output rx_ready, f_in_data, f_in_valid, f_in_sof, f_in_eol, f_mode,
    output f_out_ready, tx_data, tx_valid
  );

  // UART / filter side.
  modport slave (
    output rx_data, rx_valid, f_in_ready, f_out_data, f_out_valid, tx_ready,
    input  rx_ready, f_in_data, f_in_valid, f_in_sof, f_in_eol, f_mode,
    input  f_out_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/frame_seq_ctrl_pix_pos_cnt.sv
// Pixel position tracker: column, row and linear count within a frame.
module pix_pos_cnt
  import img_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = $clog2(IMG_W * IMG_H + 1),
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [CNT_W-1:0] count,
  output logic             last_in_line,
  output logic             last_in_frame
);

  assign last_in_line  = (col == COL_W'(IMG_W - 1));
  assign last_in_frame = last_in_line && (row == ROW_W'(IMG_H - 1));

  // Advance one pixel per accepted beat; column wraps into the next row.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col   <= '0;
      row   <= '0;
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
      if (last_in_line) begin
        col <= '0;
        row <= last_in_frame ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: feeds one frame of RX bytes into the filter, drains the
// filtered pixels to TX, and supervises the drain with an idle timeout.
module frame_seq_ctrl
  import img_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int PIX_W   = DEF_PIX_W,
  parameter int TIMEOUT = 1048576,
  localparam int TOTAL  = IMG_W * IMG_H,
  localparam int CNT_W  = $clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode_i,
  frame_seq_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_STREAM = 3'(ST_STREAM);
  localparam logic [2:0] S_FLUSH  = 3'(ST_FLUSH);
  localparam logic [2:0] S_DONE   = 3'(ST_DONE);
  localparam logic [2:0] S_ERR    = 3'(ST_ERR);

  logic [2:0]       state;
  logic [1:0]       f_mode_q;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] in_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             row_unused;
  logic             last_in_line, last_in_frame;
  logic             streaming, active, start_ok, frame_clr;
  logic             in_room, out_room, in_xfer, out_xfer;
  logic             flush_done, to_hit;
  logic [PIX_W-1:0] in_pix, out_pix;

  assign streaming = (state == S_STREAM);
  assign active    = streaming || (state == S_FLUSH);
  // abort beats start when both arrive together in IDLE.
  assign start_ok  = (state == S_IDLE) && start && !abort;
  assign frame_clr = start_ok || (active && abort);

  assign in_room  = (in_cnt < CNT_W'(TOTAL));
  assign out_room = (out_cnt < CNT_W'(TOTAL));

  // RX -> filter path is a pure pass-through while streaming.
  assign in_pix         = bus.rx_data;
  assign bus.f_in_data  = in_pix;
  assign bus.f_in_valid = streaming && bus.rx_valid && in_room;
  assign bus.rx_ready   = streaming && bus.f_in_ready && in_room;
  assign bus.f_in_sof   = streaming && (in_cnt == '0);
  assign bus.f_in_eol   = streaming && last_in_line;
  assign in_xfer        = bus.f_in_valid && bus.f_in_ready;

  // Filter -> TX path; beats beyond one frame are held off, not dropped.
  assign out_pix         = bus.f_out_data;
  assign bus.tx_data     = out_pix;
  assign bus.tx_valid    = active && bus.f_out_valid && out_room;
  assign bus.f_out_ready = active && bus.tx_ready && out_room;
  assign out_xfer        = bus.tx_valid && bus.tx_ready;

  // Completion is checked before the timeout so a last beat that lands on
  // the timeout cycle still finishes the frame.
  assign flush_done = !out_room || (out_xfer && out_cnt == CNT_W'(TOTAL - 1));
  assign to_hit     = !out_xfer && (to_cnt == TO_W'(TIMEOUT - 1));

  assign bus.f_mode = f_mode_q;
  assign busy       = active;
  assign done       = (state == S_DONE);
  assign state_o    = state;
  // Row position is tracked for the frame geometry but not needed here.
  assign row_unused = ^row;

  pix_pos_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) u_in_pos (
    .clk           (clk),
    .rst           (rst),
    .clr           (frame_clr),
    .inc           (in_xfer),
    .col           (col),
    .row           (row),
    .count         (in_cnt),
    .last_in_line  (last_in_line),
    .last_in_frame (last_in_frame)
  );

  // Sequencer FSM with output counter, idle timer and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      f_mode_q <= '0;
      out_cnt  <= '0;
      to_cnt   <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state    <= S_STREAM;
            f_mode_q <= mode_i;
            out_cnt  <= '0;
            to_cnt   <= '0;
            err      <= 1'b0;
          end
        end
        S_STREAM: begin
          if (abort) begin
            state   <= S_IDLE;
            out_cnt <= '0;
            to_cnt  <= '0;
          end else begin
            if (out_xfer) out_cnt <= out_cnt + CNT_W'(1);
            if (in_xfer && last_in_frame) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (abort) begin
            state   <= S_IDLE;
            out_cnt <= '0;
            to_cnt  <= '0;
          end else begin
            if (out_xfer) out_cnt <= out_cnt + CNT_W'(1);
            to_cnt <= out_xfer ? '0 : to_cnt + TO_W'(1);
            if (flush_done) begin
              state <= S_DONE;
            end else if (to_hit) begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_seq_ctrl.md
Name: frame_seq_ctrl

Overview:
- Frame-level sequencer between the UART byte streams and the image filter core.
- On `start` it latches the filter mode and forwards exactly IMG_W*IMG_H received pixels into the filter with start-of-frame and end-of-line markers.
- It forwards filtered pixels to UART TX until the frame is complete, then pulses `done`.
- It supervises stalls with a timeout and exposes status for the LEDs and seven-segment display.

Parameters:
- IMG_W, 64, pixels per line (≥2)
- IMG_H, 64, lines per frame (≥1)
- PIX_W, 8, pixel/byte width
- TIMEOUT, 1048576, max idle cycles in FLUSH before error
- Derived: TOTAL=IMG_W*IMG_H; CNT_W=$clog2(TOTAL+1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle frame start request
- abort  in  1  single-cycle frame abort
- mode_i  in  2  filter select, sampled on accepted start
- rx_data  in  PIX_W  byte from UART RX
- rx_valid  in  1  RX byte valid
- rx_ready  out  1  RX byte accepted
- f_in_data  out  PIX_W  pixel to filter
- f_in_valid  out  1  pixel valid
- f_in_sof  out  1  first pixel of frame
- f_in_eol  out  1  last pixel of a line
- f_in_ready  in  1  filter accepts pixel
- f_mode  out  2  latched filter mode
- f_out_data  in  PIX_W  filtered pixel
- f_out_valid  in  1  filtered pixel valid
- f_out_ready  out  1  filtered pixel accepted
- tx_data  out  PIX_W  byte to UART TX
- tx_valid  out  1  TX byte valid
- tx_ready  in  1  TX accepts byte
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- err  out  1  sticky timeout flag
- state_o  out  3  encoded FSM state for LEDs
- out_cnt  out  CNT_W  pixels sent this frame (for seven-seg)

Behaviour:
- Reset: sync to `clk`, active-high.
  - FSM enters IDLE.
  - All counters are 0 and `f_mode`=0.
  - `err`, `done`, `busy` are 0.
  - All valid/ready outputs are 0.
- Handshakes: valid/ready; a transfer occurs when both are high in the same cycle.
  - Valid is never gated by ready.
- FSM states: IDLE=0, STREAM=1, FLUSH=2, DONE=3, ERR=4.
- IDLE:
  - On `start`: latch `mode_i` into `f_mode`, clear `in_cnt`, `out_cnt`, col, row, the timeout counter and `err`; go to STREAM.
  - `start` is ignored in every other state.
- STREAM: the RX→filter path is combinational.
  - f_in_data = rx_data
  - f_in_valid = rx_valid && in_cnt<TOTAL
  - rx_ready = f_in_ready && in_cnt<TOTAL
  - f_in_sof = (in_cnt==0)
  - f_in_eol = (col==IMG_W-1)
- Input counters, per input transfer:
  - `in_cnt` increments.
  - `col` increments and wraps at IMG_W-1 to 0; on that wrap `row` increments.
- STREAM/FLUSH output path:
  - tx_data = f_out_data
  - tx_valid = f_out_valid && out_cnt<TOTAL
  - f_out_ready = tx_ready && out_cnt<TOTAL
  - Each output transfer increments `out_cnt`.
- Input and output transfers may occur in the same cycle; both counters update.
- STREAM→FLUSH on the cycle in which the TOTAL-th input transfer completes.
- FLUSH:
  - The timeout counter increments on every cycle with no output transfer and clears on each output transfer.
  - Reaching TOTAL outputs → DONE.
  - Reaching TIMEOUT → ERR.
- DONE: `done`=1 for exactly one cycle, then IDLE.
  - `out_cnt` holds its value until the next accepted start.
- ERR: sets `err`; returns to IDLE the next cycle.
- If the final output transfer and the timeout occur in the same cycle, completion wins (DONE).
- Outside STREAM/FLUSH: rx_ready=f_in_valid=f_out_ready=tx_valid=0.
  - Extra filter outputs after TOTAL are stalled, not dropped.
- `abort` in STREAM or FLUSH: next state IDLE, counters cleared, no `done`; `err` unchanged.
  - `abort` and `start` together in IDLE: `abort` wins and `start` is ignored.
- `busy` = state is STREAM or FLUSH.
- `rst` asserted mid-frame: same as reset; no `done` pulse.

Decomposition:
- Package `img_pkg`:
  - `seq_state_e` enum (3-bit, values above)
  - `filt_mode_e` (PASS=0, BLUR=1, SHARPEN=2, EDGE=3)
  - `PIX_W` default
  - default IMG_W/IMG_H localparams
- Sub-module `pix_pos_cnt`:
  - Inputs: clr, inc.
  - Outputs: col, row, count, last_in_line, last_in_frame.
  - Instantiated for the input side.
  - `out_cnt` is a plain counter in the top.

Test Plan (IMG_W=4, IMG_H=2, TOTAL=8, TIMEOUT=16 unless noted):
- Full frame: start with mode_i=2, feed bytes 0x10..0x17, filter model echoes with 2-cycle latency, tx_ready=1 → f_mode=2; f_in_sof only on 0x10; f_in_eol on 0x13 and 0x17; tx carries 8 bytes; done pulses once; out_cnt=8; FSM returns to IDLE.
- Backpressure: tx_ready toggles 1-0-1-0, f_in_ready low for 3 cycles mid-line → no lost or duplicated bytes; rx_ready low exactly while f_in_ready=0; order preserved.
- Overflow guard: RX offers 10 bytes → only 8 accepted, rx_ready=0 after the 8th; a 9th filter output stays stalled (f_out_ready=0 in DONE/IDLE).
- Timeout: filter emits only 5 outputs → ERR 16 cycles after the last output, err=1, no done; next start clears err.
- Abort: abort after 3 input transfers → IDLE next cycle, busy=0, counters 0; a following frame runs cleanly with sof on its first byte.
- Edge cases:
  - start while busy is ignored (f_mode unchanged).
  - final output and timeout in the same cycle → done=1, err=0.
  - rst mid-FLUSH → all outputs at reset values.
